// File: rtl/tlu_pkg.sv
// TLU receiver shared types: handshake FSM states and default ID width.
package tlu_pkg;

  localparam int TLU_ID_WIDTH = 15;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    CLK_HIGH,
    CLK_LOW,
    DONE,
    HOLD
  } tlu_state_t;

endpackage

// File: rtl/tlu_bit_sync.sv
// Two-flop synchroniser for the asynchronous TLU trigger/data line.
module tlu_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tlu_dut_rx.sv
// TLU trigger handshake receiver: BUSY handshake, serial ID readout, counters.
// Optional TLU_DUT_RX_ID_CHECK_EN adds ID_ERR_CNT sequence checking.
module tlu_dut_rx
  import tlu_pkg::*;
#(
  parameter int ID_WIDTH = TLU_ID_WIDTH
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST_N,
  input  logic                ENABLE,
  input  logic [7:0]          CONF_CLK_DIV,
  input  logic [15:0]         CONF_TIME_OUT,
  input  logic                DUT_VETO,
  input  logic                TLU_TRIGGER,
  output logic                TLU_BUSY,
  output logic                TLU_CLOCK,
  output logic [ID_WIDTH-1:0] TRIG_ID,
  output logic                TRIG_VALID,
  output logic [7:0]          TIMEOUT_CNT,
  output logic [31:0]         TRIG_CNT
`ifdef TLU_DUT_RX_ID_CHECK_EN
  ,
  output logic [7:0]          ID_ERR_CNT
`endif
);

  localparam int IW = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;

  tlu_state_t state_q, state_d;

  logic                trig_s;
  logic                trig_h;
  logic                rise_q;
  logic [7:0]          half;
  logic [7:0]          div_cnt;
  logic [15:0]         to_cnt;
  logic [IW-1:0]       bit_idx;
  logic [ID_WIDTH-1:0] id_q;
  logic                half_end;
  logic                to_hit;
  logic                last_bit;

  tlu_bit_sync u_sync (
    .clk   (SYS_CLK),
    .rst_n (SYS_RST_N),
    .d     (TLU_TRIGGER),
    .q     (trig_s)
  );

  // Rise strobe is registered and only armed in IDLE, so edges seen
  // during a transaction can never leak into the next one.
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      trig_h <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      trig_h <= trig_s;
      rise_q <= trig_s & ~trig_h & (state_q == IDLE);
    end
  end

  assign half     = (CONF_CLK_DIV == 8'd0) ? 8'd1 : CONF_CLK_DIV;
  assign half_end = (div_cnt == half - 8'd1);
  assign to_hit   = ({1'b0, to_cnt} + 17'd1) >= {1'b0, CONF_TIME_OUT};
  assign last_bit = (bit_idx == IW'(ID_WIDTH - 1));

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ENABLE && rise_q) state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!trig_s)     state_d = CLK_HIGH;
        else if (to_hit) state_d = IDLE;
      end
      CLK_HIGH: if (half_end) state_d = CLK_LOW;
      CLK_LOW:  if (half_end) state_d = last_bit ? DONE : CLK_HIGH;
      DONE:     state_d = HOLD;
      HOLD:     if (!DUT_VETO) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      TLU_BUSY    <= 1'b0;
      TLU_CLOCK   <= 1'b0;
      TRIG_VALID  <= 1'b0;
      TRIG_ID     <= '0;
      TIMEOUT_CNT <= 8'd0;
      TRIG_CNT    <= 32'd0;
      div_cnt     <= 8'd0;
      to_cnt      <= 16'd0;
      bit_idx     <= '0;
      id_q        <= '0;
    end else begin
      TLU_BUSY   <= (state_d != IDLE);
      TLU_CLOCK  <= (state_d == CLK_HIGH);
      TRIG_VALID <= (state_q == DONE);
      div_cnt    <= (state_d != state_q) ? 8'd0 : div_cnt + 8'd1;
      to_cnt     <= (state_q == WAIT_LOW) ? to_cnt + 16'd1 : 16'd0;
      if (state_q == WAIT_LOW && trig_s && to_hit
          && TIMEOUT_CNT != 8'hff)
        TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
      if (state_q == WAIT_LOW)
        bit_idx <= '0;
      else if (state_q == CLK_LOW && half_end && !last_bit)
        bit_idx <= bit_idx + 1'b1;
      if (state_q == CLK_LOW && half_end)
        id_q[bit_idx] <= trig_s;
      if (state_q == DONE) begin
        TRIG_ID  <= id_q;
        TRIG_CNT <= TRIG_CNT + 32'd1;
      end
    end
  end

`ifdef TLU_DUT_RX_ID_CHECK_EN
  logic                have_prev;
  logic [ID_WIDTH-1:0] id_exp;

  assign id_exp = TRIG_ID + ID_WIDTH'(1);

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      have_prev  <= 1'b0;
      ID_ERR_CNT <= 8'd0;
    end else if (state_q == DONE) begin
      have_prev <= 1'b1;
      if (have_prev && id_q != id_exp && ID_ERR_CNT != 8'hff)
        ID_ERR_CNT <= ID_ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Directed bench for tlu_dut_rx with a procedural TLU handshake model.
module tb_tlu_dut_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  div;
  logic [15:0] tout;
  logic        veto;
  logic        trig;
  logic        busy;
  logic        tclk;
  logic [14:0] trig_id;
  logic        valid;
  logic [7:0]  to_cnt;
  logic [31:0] trig_cnt;
`ifdef TLU_DUT_RX_ID_CHECK_EN
  logic [7:0]  id_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  tlu_dut_rx #(.ID_WIDTH(15)) dut (
    .SYS_CLK       (clk),
    .SYS_RST_N     (rst_n),
    .ENABLE        (en),
    .CONF_CLK_DIV  (div),
    .CONF_TIME_OUT (tout),
    .DUT_VETO      (veto),
    .TLU_TRIGGER   (trig),
    .TLU_BUSY      (busy),
    .TLU_CLOCK     (tclk),
    .TRIG_ID       (trig_id),
    .TRIG_VALID    (valid),
    .TIMEOUT_CNT   (to_cnt),
    .TRIG_CNT      (trig_cnt)
`ifdef TLU_DUT_RX_ID_CHECK_EN
    ,
    .ID_ERR_CNT    (id_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TLU side: raise trigger, drop it on BUSY, shift ID bits LSB first
  // on each TLU_CLOCK rise, release the line when TRIG_VALID appears.
  task automatic readout(input logic [14:0] id, input bit wait_fall,
                         input int drop_en_at, output int pulses,
                         output int hi_cyc, output int valids,
                         output logic [14:0] got_id);
    int n;
    bit prev;
    bit done;
    pulses = 0;
    hi_cyc = 0;
    valids = 0;
    got_id = '0;
    trig = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_rise", 32'(busy), 32'd1);
    trig = 1'b0;
    prev = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
      if (tclk) hi_cyc++;
      if (tclk && !prev) begin
        if (pulses < 15) trig = id[pulses];
        pulses++;
        if (drop_en_at != 0 && pulses == drop_en_at) en = 1'b0;
      end
      prev = tclk;
      if (valid) begin
        valids++;
        got_id = trig_id;
        trig = 1'b0;
        if (!wait_fall) done = 1'b1;
      end
      if (wait_fall && !busy) done = 1'b1;
    end
    chk("readout_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  div;
    logic [14:0] id;
    int          exp_hi;
    int          exp_cnt;
  } vec_t;

  vec_t vt[5];

  initial begin
    int pulses, hi, vals, n, k;
    bit prev, ok;
    logic [14:0] got;
    logic [14:0] pid;

    vt[0] = '{8'd4, 15'h1234, 60, 1};
    vt[1] = '{8'd3, 15'h4321, 45, 2};
    vt[2] = '{8'd5, 15'h7fff, 75, 3};
    vt[3] = '{8'd6, 15'h2aaa, 90, 4};
    vt[4] = '{8'd3, 15'h0000, 45, 5};

    rst_n = 1'b0;
    en    = 1'b1;
    div   = 8'd4;
    tout  = 16'd1000;
    veto  = 1'b0;
    trig  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tclk", 32'(tclk), 32'd0);
    chk("rst_id", 32'(trig_id), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_tocnt", 32'(to_cnt), 32'd0);
    chk("rst_trigcnt", trig_cnt, 32'd0);

    en = 1'b0;
    ok = 1'b1;
    trig = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) trig = 1'b0;
      if (busy) ok = 1'b0;
    end
    chk("en_off_no_busy", 32'(ok), 32'd1);
    en = 1'b1;
    repeat (5) tick();

    for (int v = 0; v < 5; v++) begin
      div = vt[v].div;
      readout(vt[v].id, 1'b1, 0, pulses, hi, vals, got);
      chk($sformatf("v%0d_id", v), 32'(got), 32'(vt[v].id));
      chk($sformatf("v%0d_valids", v), 32'(vals), 32'd1);
      chk($sformatf("v%0d_pulses", v), 32'(pulses), 32'd15);
      chk($sformatf("v%0d_hi", v), 32'(hi), 32'(vt[v].exp_hi));
      chk($sformatf("v%0d_cnt", v), trig_cnt, 32'(vt[v].exp_cnt));
      repeat (5) tick();
    end

    div  = 8'd4;
    tout = 16'd100;
    trig = 1'b1;
    repeat (3) tick();
    chk("busy_lat_early", 32'(busy), 32'd0);
    tick();
    chk("busy_lat_3rd", 32'(busy), 32'd1);
    n = 0;
    ok = 1'b1;
    while (busy && n < 300) begin
      tick();
      n++;
      if (valid) ok = 1'b0;
    end
    chk("to_busy_len", 32'(n), 32'd100);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy) k++;
      if (valid) ok = 1'b0;
    end
    chk("to_no_retrig", 32'(k), 32'd0);
    chk("to_no_valid", 32'(ok), 32'd1);
    chk("to_cnt", 32'(to_cnt), 32'd1);
    chk("to_trigcnt", trig_cnt, 32'd5);
    trig = 1'b0;
    tout = 16'd1000;
    repeat (5) tick();

    veto = 1'b1;
    readout(15'd5, 1'b0, 0, pulses, hi, vals, got);
    chk("veto_id", 32'(got), 32'd5);
    chk("veto_cnt", trig_cnt, 32'd6);
    ok = 1'b1;
    for (int i = 0; i < 49; i++) begin
      if (i == 10) trig = 1'b1;
      if (i == 20) trig = 1'b0;
      tick();
      if (!busy || valid) ok = 1'b0;
    end
    chk("veto_hold", 32'(ok), 32'd1);
    chk("veto_cnt_hold", trig_cnt, 32'd6);
    veto = 1'b0;
    tick();
    chk("veto_release", 32'(busy), 32'd0);
    repeat (5) tick();

    readout(15'h0abc, 1'b1, 5, pulses, hi, vals, got);
    chk("endrop_valids", 32'(vals), 32'd1);
    chk("endrop_id", 32'(got), 32'h0abc);
    chk("endrop_cnt", trig_cnt, 32'd7);
    en = 1'b1;
    repeat (5) tick();

    pid = 15'h55aa;
    trig = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    trig = 1'b0;
    pulses = 0;
    prev = 1'b0;
    n = 0;
    while (pulses < 8 && n < 2000) begin
      tick();
      n++;
      if (tclk && !prev) begin
        trig = pid[pulses];
        pulses++;
      end
      prev = tclk;
    end
    chk("mid_reach", 32'(pulses), 32'd8);
    rst_n = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_tclk", 32'(tclk), 32'd0);
    chk("mid_id", 32'(trig_id), 32'd0);
    chk("mid_tocnt", 32'(to_cnt), 32'd0);
    chk("mid_trigcnt", trig_cnt, 32'd0);
    rst_n = 1'b1;
    trig = 1'b0;
    repeat (5) tick();
    readout(15'd7, 1'b1, 0, pulses, hi, vals, got);
    chk("post_rst_id", 32'(got), 32'd7);
    chk("post_rst_cnt", trig_cnt, 32'd1);
    repeat (5) tick();

`ifdef TLU_DUT_RX_ID_CHECK_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    readout(15'd10, 1'b1, 0, pulses, hi, vals, got);
    chk("idc_first", 32'(id_err), 32'd0);
    repeat (5) tick();
    readout(15'd11, 1'b1, 0, pulses, hi, vals, got);
    chk("idc_seq", 32'(id_err), 32'd0);
    repeat (5) tick();
    readout(15'd13, 1'b1, 0, pulses, hi, vals, got);
    chk("idc_gap", 32'(id_err), 32'd1);
    repeat (5) tick();
    readout(15'h7fff, 1'b1, 0, pulses, hi, vals, got);
    chk("idc_jump", 32'(id_err), 32'd2);
    repeat (5) tick();
    readout(15'h0000, 1'b1, 0, pulses, hi, vals, got);
    chk("idc_wrap", 32'(id_err), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
